// File: rtl/tm1638_receiver.sv
// rtl/tm1638_receiver.sv - TM1638 key-scan read receiver
//
// Purpose:
//    Read-direction partner of the TM1638 byte transmitter. Once the read-key
//    command has gone out and DIO has been released, this block samples the
//    synchronised DIO on every TM1638 CLK rising-edge strobe. It assembles
//    NBYTES key-scan bytes, LSB first. Each completed byte is presented on
//    its own, and the whole scan is published atomically when the burst ends.
//
// Ports:
//    i_mclk            master clock; all logic runs on its rising edge
//    i_rst_n           asynchronous active-low reset
//    i_clk_rise        one-cycle strobe at a TM1638 CLK rising edge
//    i_dio_in          raw DIO pin, asynchronous to i_mclk
//    i_rx_start        one-cycle request to begin a burst
//    i_rx_abort        end the burst now (STB raised early)
//    o_rx_busy         high while a burst is in progress
//    o_rx_byte         last completed byte
//    o_rx_byte_valid   one-cycle pulse when o_rx_byte updates
//    o_flag_msb        high while the bit-7 slot of the current byte is pending
//    o_key_data        full scan; byte k at [8k+7:8k]
//    o_rx_done         one-cycle pulse when o_key_data updates

module tm1638_receiver #(
   parameter int NBYTES      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_mclk,
   input  logic                  i_rst_n,
   input  logic                  i_clk_rise,
   input  logic                  i_dio_in,
   input  logic                  i_rx_start,
   input  logic                  i_rx_abort,
   output logic                  o_rx_busy,
   output logic [7:0]            o_rx_byte,
   output logic                  o_rx_byte_valid,
   output logic                  o_flag_msb,
   output logic [8*NBYTES-1:0]   o_key_data,
   output logic                  o_rx_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [SYNC_STAGES-1:0]  r_sync;
   logic [7:0]              r_shift;
   logic [2:0]              r_bit_cnt;
   logic [2:0]              r_byte_cnt;
   logic [8*NBYTES-1:0]     r_stage;
   logic [8*NBYTES-1:0]     r_key_data;
   logic [7:0]              r_rx_byte;
   logic                    r_rx_byte_valid;
   logic                    r_rx_done;
   logic                    r_rx_busy;

   logic                    w_dio_s;
   logic                    w_start;
   logic                    w_bit_take;
   logic                    w_byte_end;
   logic                    w_last_byte;
   logic [7:0]              w_byte_new;

   assign w_dio_s     = r_sync[SYNC_STAGES-1];
   // Abort outranks both a start request and a data strobe.
   assign w_start     = (r_state == S_IDLE) && i_rx_start && !i_rx_abort;
   assign w_bit_take  = (r_state == S_RECV) && i_clk_rise && !i_rx_abort;
   assign w_byte_end  = w_bit_take && (r_bit_cnt == 3'd7);
   assign w_last_byte = (r_byte_cnt == LAST_BYTE);
   // Bits arrive LSB first, so each new bit enters at the top and the byte
   // shifts right.
   assign w_byte_new  = {w_dio_s, r_shift[7:1]};

   // DIO synchroniser. It resets to 1, the idle level of a released DIO line.
   always_ff @(posedge i_mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_dio_in};
      end
   end

   always_ff @(posedge i_mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = S_RECV;
            end
         end
         S_RECV: begin
            if (i_rx_abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_byte_end && w_last_byte) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift         <= '0;
         r_bit_cnt       <= '0;
         r_byte_cnt      <= '0;
         r_stage         <= '0;
         r_key_data      <= '0;
         r_rx_byte       <= '0;
         r_rx_byte_valid <= 1'b0;
         r_rx_done       <= 1'b0;
         r_rx_busy       <= 1'b0;
      end else begin
         r_rx_byte_valid <= 1'b0;
         r_rx_done       <= 1'b0;
         // Busy follows the next state, so it rises the cycle after start.
         // It also falls in the same cycle that o_rx_done pulses.
         r_rx_busy       <= (w_state_nxt != S_IDLE);

         if (w_start) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_stage    <= '0;
         end

         if (w_bit_take) begin
            r_shift   <= w_byte_new;
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end

         if (w_byte_end) begin
            r_rx_byte       <= w_byte_new;
            r_rx_byte_valid <= 1'b1;
            for (int k = 0; k < NBYTES; k++) begin
               if (r_byte_cnt == 3'(k)) begin
                  r_stage[8*k +: 8] <= w_byte_new;
               end
            end
            if (!w_last_byte) begin
               r_byte_cnt <= r_byte_cnt + 3'd1;
            end
         end

         // Publish the scan as the DONE cycle ends, unless an abort arrives
         // in that same cycle.
         if ((r_state == S_DONE) && !i_rx_abort) begin
            r_key_data <= r_stage;
            r_rx_done  <= 1'b1;
         end
      end
   end

   assign o_rx_busy       = r_rx_busy;
   assign o_rx_byte       = r_rx_byte;
   assign o_rx_byte_valid = r_rx_byte_valid;
   assign o_flag_msb      = (r_state == S_RECV) && (r_bit_cnt == 3'd7);
   assign o_key_data      = r_key_data;
   assign o_rx_done       = r_rx_done;

endmodule

// File: tb/tb_tm1638_receiver.sv
// tb/tb_tm1638_receiver.sv - self-checking bench for tm1638_receiver
module tb_tm1638_receiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n    = 1'b0;
   logic clk_rise = 1'b0;
   logic dio      = 1'b1;
   logic rx_start = 1'b0;
   logic rx_abort = 1'b0;

   logic        w_busy, w_valid, w_flag, w_done;
   logic [7:0]  w_byte;
   logic [31:0] w_key;
   logic        w1_busy, w1_valid, w1_flag, w1_done;
   logic [7:0]  w1_byte;
   logic [7:0]  w1_key;

   tm1638_receiver #(.NBYTES(4), .SYNC_STAGES(2)) dut (
      .i_mclk(clk), .i_rst_n(rst_n), .i_clk_rise(clk_rise), .i_dio_in(dio),
      .i_rx_start(rx_start), .i_rx_abort(rx_abort),
      .o_rx_busy(w_busy), .o_rx_byte(w_byte), .o_rx_byte_valid(w_valid),
      .o_flag_msb(w_flag), .o_key_data(w_key), .o_rx_done(w_done)
   );

   tm1638_receiver #(.NBYTES(1), .SYNC_STAGES(2)) dut1 (
      .i_mclk(clk), .i_rst_n(rst_n), .i_clk_rise(clk_rise), .i_dio_in(dio),
      .i_rx_start(rx_start), .i_rx_abort(rx_abort),
      .o_rx_busy(w1_busy), .o_rx_byte(w1_byte), .o_rx_byte_valid(w1_valid),
      .o_flag_msb(w1_flag), .o_key_data(w1_key), .o_rx_done(w1_done)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   // Observation log, written only by this monitor.
   logic [7:0]  got_q[$];
   int          last_valid_cyc = 0;
   logic        busy_at_last_valid = 1'b0;
   int          n_done = 0;
   int          done_cyc = 0;
   logic [31:0] done_key = '0;
   logic        busy_at_done = 1'b0;
   logic [31:0] prev_key = '0;
   int          key_glitch = 0;

   always @(negedge clk) begin
      if (w_valid === 1'b1) begin
         got_q.push_back(w_byte);
         last_valid_cyc = cyc;
         busy_at_last_valid = w_busy;
      end
      if (w_done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
         done_key = w_key;
         busy_at_done = w_busy;
      end
      if (rst_n && (w_done !== 1'b1) && (w_key !== prev_key)) key_glitch++;
      prev_key = w_key;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // DIO is held for four cycles before the strobe, which covers the
   // synchroniser settle requirement.
   task automatic send_bit(input logic b);
      dio = b;
      repeat (4) tick();
      clk_rise = 1'b1;
      tick();
      clk_rise = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (w_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", w_busy); end
      checks++; if (w_byte !== 8'h00)  begin errors++; $display("FAIL reset_byte: got %h expected 00", w_byte); end
      checks++; if (w_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", w_valid); end
      checks++; if (w_flag !== 1'b0)   begin errors++; $display("FAIL reset_flag: got %b expected 0", w_flag); end
      checks++; if (w_key !== 32'h0)   begin errors++; $display("FAIL reset_key: got %h expected 0", w_key); end
      checks++; if (w_done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", w_done); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_normal_burst(input logic [31:0] word);
      int base, nd0;
      logic [7:0] exp_b;
      base = got_q.size();
      nd0  = n_done;
      checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL burst_idle_busy: got %b expected 0", w_busy); end
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL burst_busy_rise: got %b expected 1", w_busy); end
      for (int i = 0; i < 32; i++) send_bit(word[i]);
      repeat (3) tick();
      checks++; if (got_q.size() - base != 4) begin errors++; $display("FAIL burst_nbytes: got %0d expected 4", got_q.size() - base); end
      for (int k = 0; k < 4; k++) begin
         exp_b = 8'((word >> (8 * k)) & 32'hFF);
         if (got_q.size() > base + k) begin
            checks++;
            if (got_q[base+k] !== exp_b) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", k, got_q[base+k], exp_b); end
         end
      end
      checks++; if (n_done - nd0 != 1) begin errors++; $display("FAIL burst_done_count: got %0d expected 1", n_done - nd0); end
      checks++; if (done_cyc != last_valid_cyc + 1) begin errors++; $display("FAIL burst_done_latency: got %0d expected %0d", done_cyc, last_valid_cyc + 1); end
      checks++; if (done_key !== word) begin errors++; $display("FAIL burst_key_at_done: got %h expected %h", done_key, word); end
      checks++; if (w_key !== word) begin errors++; $display("FAIL burst_key: got %h expected %h", w_key, word); end
      checks++; if (busy_at_last_valid !== 1'b1) begin errors++; $display("FAIL burst_busy_at_last_byte: got %b expected 1", busy_at_last_valid); end
      checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL burst_busy_at_done: got %b expected 0", busy_at_done); end
   endtask

   task automatic test_flag();
      logic [7:0] b;
      b = 8'hA5;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (w1_flag !== (i == 7)) begin errors++; $display("FAIL flag_before_bit%0d: got %b expected %b", i, w1_flag, (i == 7)); end
         checks++; if (w_flag !== (i == 7))  begin errors++; $display("FAIL flag4_before_bit%0d: got %b expected %b", i, w_flag, (i == 7)); end
         send_bit(b[i]);
      end
      checks++; if (w1_flag !== 1'b0)  begin errors++; $display("FAIL flag_after_byte: got %b expected 0", w1_flag); end
      checks++; if (w1_byte !== 8'hA5) begin errors++; $display("FAIL flag_rx_byte: got %h expected a5", w1_byte); end
      repeat (2) tick();
      checks++; if (w1_key !== 8'hA5)  begin errors++; $display("FAIL flag_key: got %h expected a5", w1_key); end
      checks++; if (w1_busy !== 1'b0)  begin errors++; $display("FAIL flag_busy_end: got %b expected 0", w1_busy); end
      rx_abort = 1'b1;
      tick();
      rx_abort = 1'b0;
   endtask

   task automatic test_collision();
      logic [7:0] b;
      int base, nd0;
      b = 8'h3C;
      base = got_q.size();
      nd0  = n_done;
      dio = 1'b1;
      repeat (4) tick();
      rx_start = 1'b1;
      clk_rise = 1'b1;
      tick();
      rx_start = 1'b0;
      clk_rise = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      tick();
      checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL collide_nbytes: got %0d expected 1", got_q.size() - base); end
      if (got_q.size() > base) begin
         checks++; if (got_q[base] !== 8'h3C) begin errors++; $display("FAIL collide_byte: got %h expected 3c", got_q[base]); end
      end
      rx_abort = 1'b1;
      tick();
      rx_abort = 1'b0;
      checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL collide_abort_busy: got %b expected 0", w_busy); end
      checks++; if (n_done != nd0) begin errors++; $display("FAIL collide_no_done: got %0d expected %0d", n_done, nd0); end
   endtask

   task automatic test_abort();
      int base, nd0;
      base = got_q.size();
      nd0  = n_done;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
      rx_abort = 1'b1;
      tick();
      rx_abort = 1'b0;
      checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", w_busy); end
      repeat (5) tick();
      checks++; if (n_done != nd0) begin errors++; $display("FAIL abort_no_done: got %0d expected %0d", n_done, nd0); end
      checks++; if (w_key !== 32'h44001001) begin errors++; $display("FAIL abort_key_kept: got %h expected 44001001", w_key); end
      checks++; if (w_byte !== 8'hFF) begin errors++; $display("FAIL abort_rx_byte: got %h expected ff", w_byte); end
      checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL abort_nbytes: got %0d expected 1", got_q.size() - base); end
      // Start and abort together in IDLE: abort wins.
      rx_start = 1'b1;
      rx_abort = 1'b1;
      tick();
      rx_start = 1'b0;
      rx_abort = 1'b0;
      checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL abort_start_collide: got %b expected 0", w_busy); end
   endtask

   task automatic test_ignored(input logic [31:0] word);
      int base, nd0;
      base = got_q.size();
      nd0  = n_done;
      dio = 1'b1;
      repeat (4) tick();
      clk_rise = 1'b1;
      tick();
      clk_rise = 1'b0;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         send_bit(word[i]);
         if (i == 3 || i == 20) begin
            rx_start = 1'b1;
            tick();
            rx_start = 1'b0;
         end
      end
      repeat (3) tick();
      checks++; if (got_q.size() - base != 4) begin errors++; $display("FAIL ignored_nbytes: got %0d expected 4", got_q.size() - base); end
      for (int k = 0; k < 4; k++) begin
         if (got_q.size() > base + k) begin
            checks++;
            if (got_q[base+k] !== 8'((word >> (8 * k)) & 32'hFF)) begin errors++; $display("FAIL ignored_byte%0d: got %h expected %h", k, got_q[base+k], 8'((word >> (8 * k)) & 32'hFF)); end
         end
      end
      checks++; if (n_done - nd0 != 1) begin errors++; $display("FAIL ignored_done_count: got %0d expected 1", n_done - nd0); end
      checks++; if (w_key !== word) begin errors++; $display("FAIL ignored_key: got %h expected %h", w_key, word); end
   endtask

   task automatic test_async_reset();
      logic [31:0] word;
      word = $urandom | 32'h1;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 12; i++) send_bit(word[i]);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (w_busy !== 1'b0)  begin errors++; $display("FAIL areset_busy: got %b expected 0", w_busy); end
      checks++; if (w_byte !== 8'h00) begin errors++; $display("FAIL areset_byte: got %h expected 00", w_byte); end
      checks++; if (w_key !== 32'h0)  begin errors++; $display("FAIL areset_key: got %h expected 0", w_key); end
      checks++; if (w_flag !== 1'b0)  begin errors++; $display("FAIL areset_flag: got %b expected 0", w_flag); end
      checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", w_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_normal_burst($urandom);
   endtask

   initial begin
      test_reset();
      test_normal_burst(32'h44001001);
      for (int r = 0; r < 3; r++) test_normal_burst($urandom);
      test_flag();
      test_collision();
      test_normal_burst(32'h44001001);
      test_abort();
      test_ignored(32'h44001001);
      test_async_reset();
      checks++; if (key_glitch != 0) begin errors++; $display("FAIL key_stable: got %0d unexpected changes expected 0", key_glitch); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tm1638_receiver.md
Name: tm1638_receiver

Overview:
- Read-direction counterpart of the TM1638 byte transmitter.
- After the controller has sent the read-key command (0x42) and released DIO, this block samples DIO on each TM1638 CLK rising-edge strobe and assembles NBYTES key-scan bytes, LSB first.
- Each byte is presented as it completes, and the whole scan is published atomically at the end.
- Sits beside the transmitter under the TM1638 interface controller and shares its mclk domain and clock-edge strobes.

Parameters:
- NBYTES, 4, number of bytes per read burst (TM1638 key scan = 4); legal range 1..8.
- SYNC_STAGES, 2, flip-flop stages in the dio_in synchronizer; legal range ≥2.

Ports:
- mclk  input  1  master 16 MHz clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- clk_rise  input  1  one-mclk-cycle strobe marking a TM1638 CLK rising edge (data-valid edge).
- dio_in  input  1  raw DIO pin value, asynchronous to mclk.
- rx_start  input  1  one-cycle request to begin a burst.
- rx_abort  input  1  terminate the burst immediately (STB raised early).
- rx_busy  output  1  high while a burst is in progress.
- rx_byte  output  8  last completed byte.
- rx_byte_valid  output  1  one-cycle pulse when rx_byte updates.
- flag_msb  output  1  high while the bit-7 slot of the current byte is pending.
- key_data  output  8*NBYTES  full scan; byte k occupies bits [8k+7:8k].
- rx_done  output  1  one-cycle pulse when key_data updates.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; synchronizer flops=1; every output=0; staging register, bit counter and byte counter =0.
- Synchronizer: dio_in passes through SYNC_STAGES flops to give dio_s. All sampling uses dio_s. The strobe generator guarantees DIO is stable ≥SYNC_STAGES+1 mclk cycles before clk_rise.
- States:
  - IDLE → RECV on rx_start. Clears bit_cnt, byte_cnt and the staging register. A clk_rise in the same cycle is ignored; the first bit is taken at the next clk_rise.
  - RECV, on clk_rise: shift <= {dio_s, shift[7:1]}; bit_cnt++.
  - RECV, on clk_rise with bit_cnt==7 (byte complete):
    - rx_byte <= {dio_s, shift[7:1]}; rx_byte_valid=1 for the next cycle.
    - Staging[byte_cnt] <= the same value; bit_cnt wraps to 0.
    - If byte_cnt==NBYTES-1 → DONE, else byte_cnt++.
  - DONE (one cycle): key_data <= staging; rx_done=1 for this single cycle; → IDLE.
- Outputs:
  - rx_busy = (state != IDLE), registered; it rises the cycle after rx_start.
  - flag_msb = 1 in RECV while bit_cnt==7; cleared on the completing clk_rise.
- Latency:
  - rx_byte_valid is asserted the mclk cycle after the 8th clk_rise of that byte.
  - rx_done is asserted the cycle after the final rx_byte_valid.
- Boundary conditions:
  - rx_start while busy: ignored.
  - clk_rise in IDLE or DONE: ignored.
  - rx_abort in RECV or DONE (priority over clk_rise and DONE completion): → IDLE next cycle. No rx_done; key_data keeps its previous value. rx_byte keeps any byte already completed. Staging is discarded.
  - rx_abort in IDLE: no effect.
  - rx_start and rx_abort asserted together in IDLE: abort wins; stay IDLE.
  - Reset mid-burst: immediate return to the reset values above, including key_data=0.
  - key_data never changes except in DONE or on reset.

Test Plan:
- Normal burst: rx_start, then 32 clk_rise strobes with DIO carrying 0x01,0x10,0x00,0x44 LSB first → four rx_byte_valid pulses with those values; rx_done one cycle after the last; key_data=0x44001001; rx_busy falls with rx_done.
- Bit order and flag: single byte 0xA5 (NBYTES=1 build) → flag_msb high only between the 7th and 8th clk_rise; rx_byte=0xA5; key_data=0xA5.
- Start/edge collision: rx_start and clk_rise in the same cycle, DIO=1 at that strobe, then 8 strobes of 0x3C → first byte 0x3C (colliding strobe not sampled).
- Abort: preload key_data=0x44001001 via a full burst; start a new burst, send byte 0xFF plus 3 bits, assert rx_abort → rx_busy low next cycle; no rx_done; key_data unchanged; rx_byte=0xFF.
- Ignored requests: rx_start pulsed mid-byte and clk_rise pulsed in IDLE → no counter disturbance; burst result identical to the normal-burst case.
- Async reset: drop rst_n between mclk edges mid-burst → all outputs 0 immediately; after release, a fresh burst completes correctly.
